// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
// Bundles the request/response and shift-register control signals of the
// shift sequencer.
//   master : requester side. It drives start/abort/txData and observes the
//            sequencer outputs.
//   slave  : sequencer side. It consumes start/abort/txData and drives
//            loadData, pLoad, shiftEn, sclk, csN, busy, done and bitCount.
// Clock and reset are not carried here. They stay plain module ports.
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
  parameter int WIDTH = 8
) ();

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] txData;
  logic [WIDTH-1:0] loadData;
  logic             pLoad;
  logic             shiftEn;
  logic             sclk;
  logic             csN;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bitCount;

  modport master (
    output start,
    output abort,
    output txData,
    input  loadData,
    input  pLoad,
    input  shiftEn,
    input  sclk,
    input  csN,
    input  busy,
    input  done,
    input  bitCount
  );

  modport slave (
    input  start,
    input  abort,
    input  txData,
    output loadData,
    output pLoad,
    output shiftEn,
    output sclk,
    output csN,
    output busy,
    output done,
    output bitCount
  );

endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Sequences one shift register through a complete serial transfer.
// 1. A parallel-load strobe is issued.
// 2. WIDTH shift-enable strobes follow, each timed to the end of an sclk high
//    phase.
// 3. csN frames the whole transfer, from the load cycle to the last shift.
// 4. A one-cycle done pulse ends the transfer.
//
// Parameters
//   WIDTH  : bits per transfer (number of shift pulses), >= 2
//   DIVIDE : clk cycles per sclk half-period, >= 1
//
// Ports
//   clk    : system clock, rising-edge active
//   resetN : asynchronous active-low reset
//   bus    : shift_sequencer_if.slave
//            inputs  : start, abort, txData
//            outputs : loadData, pLoad, shiftEn, sclk, csN, busy, done,
//                      bitCount
//
// Every output is decoded from registered state only. No input reaches an
// output within the same cycle.
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DIVIDE = 4
) (
  input  logic                clk,
  input  logic                resetN,
  shift_sequencer_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  // The phase counter needs at least one bit, even when DIVIDE is 1.
  localparam int PH_W  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DIVIDE - 1);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LOW    = 3'd2,
    HIGH   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] ldata_q, ldata_d;

  logic             phase_last;
  logic [CNT_W-1:0] bitcnt_inc;

  assign phase_last = (phase_q == PH_LAST);
  assign bitcnt_inc = bitcnt_q + CNT_W'(1);

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bitcnt_q <= '0;
      ldata_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      ldata_q  <= ldata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    ldata_d  = ldata_q;

    unique case (state_q)
      IDLE: begin
        // When abort and start arrive together, abort wins.
        if (bus.start && !bus.abort) begin
          state_d  = LOAD;
          ldata_d  = bus.txData;
          bitcnt_d = '0;
          phase_d  = '0;
        end
      end

      LOAD: begin
        state_d = LOW;
        phase_d = '0;
      end

      LOW: begin
        if (phase_last) begin
          state_d = HIGH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      HIGH: begin
        if (phase_last) begin
          // shiftEn is active this cycle, so the shift counts as done.
          bitcnt_d = bitcnt_inc;
          phase_d  = '0;
          state_d  = (bitcnt_inc == CNT_FINAL) ? FINISH : LOW;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
        phase_d = '0;
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Abort cancels the transfer from any active state. bitCount keeps the
    // number of shifts already issued.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      phase_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.pLoad    = 1'b0;
    bus.shiftEn  = 1'b0;
    bus.sclk     = 1'b0;
    bus.csN      = 1'b1;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.loadData = ldata_q;
    bus.bitCount = bitcnt_q;

    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
      end
      LOAD: begin
        bus.pLoad = 1'b1;
        bus.csN   = 1'b0;
      end
      LOW: begin
        bus.csN = 1'b0;
      end
      HIGH: begin
        bus.csN     = 1'b0;
        bus.sclk    = 1'b1;
        // The strobe sits in the last high cycle, just before sclk falls.
        bus.shiftEn = phase_last;
      end
      FINISH: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(8)) if0 ();
  shift_sequencer_if #(.WIDTH(8)) if1 ();

  shift_sequencer #(.WIDTH(8), .DIVIDE(4)) dut0 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (if0.slave)
  );

  shift_sequencer #(.WIDTH(8), .DIVIDE(1)) dut1 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (if1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Packed view: {pLoad, shiftEn, sclk, csN, busy, done}
  logic [5:0] obs0, obs1;
  assign obs0 = {if0.pLoad, if0.shiftEn, if0.sclk, if0.csN, if0.busy, if0.done};
  assign obs1 = {if1.pLoad, if1.shiftEn, if1.sclk, if1.csN, if1.busy, if1.done};

  localparam logic [5:0] IDLE_VEC = 6'b000100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN     = 1'b0;
    if0.start  = 1'b0; if0.abort = 1'b0; if0.txData = 8'h00;
    if1.start  = 1'b0; if1.abort = 1'b0; if1.txData = 8'h00;
    #2;
    n_cmp++;
    if (obs0 !== IDLE_VEC) begin
      n_bad++; $display("FAIL reset_outputs: got %b want %b", obs0, IDLE_VEC);
    end
    n_cmp++;
    if (if0.loadData !== 8'h00 || if0.bitCount !== 4'd0) begin
      n_bad++; $display("FAIL reset_regs: loadData %h bitCount %0d want 00/0", if0.loadData, if0.bitCount);
    end
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    tick();
    n_cmp++;
    if (obs0 !== IDLE_VEC || obs1 !== IDLE_VEC) begin
      n_bad++; $display("FAIL reset_release: got %b/%b want %b", obs0, obs1, IDLE_VEC);
    end
  endtask

  task automatic test_nominal();
    logic [5:0] exp;
    if0.txData = 8'hA5;
    if0.start  = 1'b1;
    tick();
    if0.start  = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      exp = {c == 1,
             (c >= 2 && c <= 65 && ((c - 1) % 8) == 0),
             (c >= 2 && c <= 65 && ((c - 2) % 8) >= 4),
             !(c >= 1 && c <= 65),
             (c >= 1 && c <= 66),
             c == 66};
      n_cmp++;
      if (obs0 !== exp) begin
        n_bad++; $display("FAIL nominal cyc%0d: {pLoad,shiftEn,sclk,csN,busy,done} got %b want %b", c, obs0, exp);
      end
      if (c == 1) begin
        n_cmp++;
        if (if0.loadData !== 8'hA5) begin
          n_bad++; $display("FAIL nominal_loadData: got %h want a5", if0.loadData);
        end
      end
      tick();
    end
    n_cmp++;
    if (if0.bitCount !== 4'd8) begin
      n_bad++; $display("FAIL nominal_bitCount: got %0d want 8", if0.bitCount);
    end
  endtask

  task automatic test_back_to_back();
    bit got_done;
    if0.txData = 8'h3C;
    if0.start  = 1'b1;
    tick();
    if0.txData = 8'hC3;
    for (int c = 1; c <= 68; c++) begin
      if (c == 1 || c == 30) begin
        n_cmp++;
        if (if0.loadData !== 8'h3C) begin
          n_bad++; $display("FAIL b2b_first_load cyc%0d: got %h want 3c", c, if0.loadData);
        end
      end
      if (c == 66) begin
        n_cmp++;
        if (if0.done !== 1'b1) begin
          n_bad++; $display("FAIL b2b_done66: got %b want 1", if0.done);
        end
      end
      if (c == 67) begin
        n_cmp++;
        if (obs0 !== IDLE_VEC) begin
          n_bad++; $display("FAIL b2b_idle67: got %b want %b", obs0, IDLE_VEC);
        end
      end
      if (c == 68) begin
        n_cmp++;
        if (if0.pLoad !== 1'b1 || if0.loadData !== 8'hC3) begin
          n_bad++; $display("FAIL b2b_second_load: pLoad %b loadData %h want 1/c3", if0.pLoad, if0.loadData);
        end
        if0.start = 1'b0;
      end
      if (c < 68) tick();
    end
    got_done = 1'b0;
    for (int i = 0; i < 80 && !got_done; i++) begin
      tick();
      if (if0.done === 1'b1) got_done = 1'b1;
    end
    n_cmp++;
    if (!got_done || if0.bitCount !== 4'd8) begin
      n_bad++; $display("FAIL b2b_second_done: done_seen %b bitCount %0d want 1/8", got_done, if0.bitCount);
    end
    tick();
  endtask

  task automatic test_abort();
    if0.txData = 8'h5A;
    if0.start  = 1'b1;
    tick();
    if0.start  = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      if (c == 25) begin
        n_cmp++;
        if (if0.shiftEn !== 1'b1) begin
          n_bad++; $display("FAIL abort_third_shift: got %b want 1", if0.shiftEn);
        end
      end
      if (c == 27) if0.abort = 1'b1;
      tick();
    end
    if0.abort = 1'b0;
    n_cmp++;
    if (obs0 !== IDLE_VEC || if0.bitCount !== 4'd3) begin
      n_bad++; $display("FAIL abort_cyc28: outs %b bitCount %0d want %b/3", obs0, if0.bitCount, IDLE_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs0 !== IDLE_VEC || if0.bitCount !== 4'd3) begin
        n_bad++; $display("FAIL abort_hold%0d: outs %b bitCount %0d want %b/3", i, obs0, if0.bitCount, IDLE_VEC);
      end
    end
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    n_cmp++;
    if (if0.pLoad !== 1'b1 || if0.bitCount !== 4'd0) begin
      n_bad++; $display("FAIL abort_restart: pLoad %b bitCount %0d want 1/0", if0.pLoad, if0.bitCount);
    end
    tick();
    if0.abort = 1'b1;
    tick();
    if0.abort = 1'b0;
    n_cmp++;
    if (obs0 !== IDLE_VEC) begin
      n_bad++; $display("FAIL abort_in_low: got %b want %b", obs0, IDLE_VEC);
    end
  endtask

  task automatic test_ignored();
    int dones;
    logic [7:0] td;
    if0.start = 1'b1;
    if0.abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs0 !== IDLE_VEC) begin
        n_bad++; $display("FAIL start_abort_idle%0d: got %b want %b", i, obs0, IDLE_VEC);
      end
    end
    if0.start  = 1'b0;
    if0.abort  = 1'b0;
    if0.txData = 8'h11;
    if0.start  = 1'b1;
    tick();
    if0.start  = 1'b0;
    dones = 0;
    for (int c = 1; c <= 80; c++) begin
      if (if0.done === 1'b1) dones++;
      if (c == 50) begin
        n_cmp++;
        if (if0.loadData !== 8'h11) begin
          n_bad++; $display("FAIL busy_loadData: got %h want 11", if0.loadData);
        end
      end
      if (c == 5 || c == 20 || c == 40 || c == 60) begin
        td = 8'h22 + 8'(c);
        if0.txData = td;
        if0.start  = 1'b1;
      end else begin
        if0.start  = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++; $display("FAIL busy_done_count: got %0d want 1", dones);
    end
    n_cmp++;
    if (if0.loadData !== 8'h11 || if0.busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_end: loadData %h busy %b want 11/0", if0.loadData, if0.busy);
    end
  endtask

  task automatic test_reset_mid();
    if0.txData = 8'h77;
    if0.start  = 1'b1;
    tick();
    if0.start  = 1'b0;
    for (int c = 1; c < 25; c++) tick();
    n_cmp++;
    if (if0.shiftEn !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_third_shift: got %b want 1", if0.shiftEn);
    end
    #2;
    resetN = 1'b0;
    #1;
    n_cmp++;
    if (obs0 !== IDLE_VEC || if0.loadData !== 8'h00 || if0.bitCount !== 4'd0) begin
      n_bad++; $display("FAIL rstmid_async: outs %b loadData %h bitCount %0d want %b/00/0",
                        obs0, if0.loadData, if0.bitCount, IDLE_VEC);
    end
    tick();
    #3;
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (obs0 !== IDLE_VEC) begin
        n_bad++; $display("FAIL rstmid_after%0d: got %b want %b", i, obs0, IDLE_VEC);
      end
    end
  endtask

  task automatic test_divide1();
    logic [5:0] exp;
    if1.txData = 8'h96;
    if1.start  = 1'b1;
    tick();
    if1.start  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp = {c == 1,
             (c >= 2 && c <= 17 && ((c - 1) % 2) == 0),
             (c >= 2 && c <= 17 && ((c - 2) % 2) >= 1),
             !(c >= 1 && c <= 17),
             (c >= 1 && c <= 18),
             c == 18};
      n_cmp++;
      if (obs1 !== exp) begin
        n_bad++; $display("FAIL div1 cyc%0d: {pLoad,shiftEn,sclk,csN,busy,done} got %b want %b", c, obs1, exp);
      end
      if (c == 1) begin
        n_cmp++;
        if (if1.loadData !== 8'h96) begin
          n_bad++; $display("FAIL div1_loadData: got %h want 96", if1.loadData);
        end
      end
      tick();
    end
    n_cmp++;
    if (if1.bitCount !== 4'd8) begin
      n_bad++; $display("FAIL div1_bitCount: got %0d want 8", if1.bitCount);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_abort();
    test_ignored();
    test_divide1();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
